// File: rtl/cv32e41s_pmp_csr_regs_if.sv
// rtl/cv32e41s_pmp_csr_regs_if.sv - PMP CSR state types and the CSR request/response bus interface
package cv32e41s_pmp_csr_pkg;

  typedef enum logic [1:0] {
    PMP_OFF   = 2'b00,
    PMP_TOR   = 2'b01,
    PMP_NA4   = 2'b10,
    PMP_NAPOT = 2'b11
  } pmp_mode_e;

  typedef enum logic [1:0] {
    CSR_READ  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_e;

  // One pmpcfg byte: L, two reserved bits (always 0), A, X, W, R
  typedef struct packed {
    logic      lock;
    logic [1:0] zero;
    pmp_mode_e mode;
    logic      exec;
    logic      write;
    logic      read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } mseccfg_t;

  typedef struct packed {
    pmp_cfg_t [15:0]        cfg;
    logic     [15:0][33:0]  addr;
    logic     [15:0][31:0]  pmraddroff;
    mseccfg_t               mseccfg;
  } pmp_csr_t;

endpackage

interface cv32e41s_pmp_csr_regs_if;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_addr, req_op, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/cv32e41s_pmp_csr_regs.sv
// rtl/cv32e41s_pmp_csr_regs.sv - PMP/PMR CSR register file with lock and WARL legalisation (PMR offset CSRs under XPMP_PMR_CSR_EN)
module cv32e41s_pmp_csr_regs
  import cv32e41s_pmp_csr_pkg::*;
#(
  parameter int          PMP_GRANULARITY = 0,
  parameter int          PMP_NUM_REGIONS = 1,
  parameter logic [11:0] PMR_OFF_BASE    = 12'hBD0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cv32e41s_pmp_csr_regs_if.slave        csr_bus,
  output pmp_csr_t                      csr_pmp_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CHECK  = 2'b01,
    S_COMMIT = 2'b10,
    S_RESP   = 2'b11
  } state_e;

  state_e state_q, state_d;

  // Captured request
  logic [11:0] req_addr_q;
  logic [1:0]  req_op_q;
  logic [31:0] req_wdata_q;

  // Results of the CHECK stage
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] new_q;
  logic [3:0]  cfg_we_q;
  logic        addr_we_q;
  logic        msec_we_q;
  logic        rlb_we_q;
  logic        pmr_we_q;

  // Protection state
  pmp_cfg_t [15:0]       pmp_cfg_q,  pmp_cfg_d;
  logic     [15:0][33:0] pmp_addr_q, pmp_addr_d;
  mseccfg_t              mseccfg_q,  mseccfg_d;
`ifdef XPMP_PMR_CSR_EN
  logic     [15:0][31:0] pmr_off_q,  pmr_off_d;
`endif

  // Combinational decode / check signals
  logic        hit_cfg, hit_addr, hit_msec, sel_pmr;
  logic [11:0] pmr_rel;
  logic [3:0]  idx, idx_nxt;
  logic [31:0] old_val, new_val;
  logic        dec_err, do_wr, addr_lock, any_lock;
  logic [3:0]  cfg_we;
  logic        addr_we, msec_we, rlb_we, pmr_we;

  // Address read-back shaping for coarse granularity; the stored value is untouched
  function automatic logic [31:0] addr_rd(input logic [31:0] val, input pmp_mode_e mode);
    logic [31:0] r;
    r = val;
    for (int b = 0; b < 32; b++) begin
      if (mode == PMP_NAPOT && b <= PMP_GRANULARITY - 2) begin
        r[b] = 1'b1;
      end else if ((mode == PMP_OFF || mode == PMP_TOR) && PMP_GRANULARITY >= 2 &&
                   b <= PMP_GRANULARITY - 1) begin
        r[b] = 1'b0;
      end
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: one request walks IDLE->CHECK->COMMIT->RESP, RESP waits for the consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (csr_bus.req_valid) state_d = S_CHECK;
      S_CHECK:  state_d = S_COMMIT;
      S_COMMIT: state_d = S_RESP;
      S_RESP:   if (csr_bus.resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture on handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_addr_q  <= '0;
      req_op_q    <= '0;
      req_wdata_q <= '0;
    end else if (state_q == S_IDLE && csr_bus.req_valid) begin
      req_addr_q  <= csr_bus.req_addr;
      req_op_q    <= csr_bus.req_op;
      req_wdata_q <= csr_bus.req_wdata;
    end
  end

  // Address decode; PMR window is decoded in every build so it can be rejected explicitly
  always_comb begin
    pmr_rel  = req_addr_q - PMR_OFF_BASE;
    hit_cfg  = (req_addr_q[11:2] == 10'h0E8);
    hit_addr = (req_addr_q[11:4] == 8'h3B);
    hit_msec = (req_addr_q == 12'h747);
    sel_pmr  = !hit_cfg && !hit_addr && !hit_msec && (pmr_rel[11:4] == 8'h00);
    idx      = hit_addr ? req_addr_q[3:0] : pmr_rel[3:0];
    idx_nxt  = idx + 4'd1;
  end

  // Old value, new value and lock evaluation for the captured request
  always_comb begin
    old_val = '0;
    dec_err = 1'b0;
    if (hit_cfg) begin
      for (int b = 0; b < 4; b++) begin
        old_val[8*b +: 8] = pmp_cfg_q[{req_addr_q[1:0], 2'(b)}];
      end
    end else if (hit_addr) begin
      old_val = addr_rd(pmp_addr_q[idx][33:2], pmp_cfg_q[idx].mode);
`ifdef XPMP_PMR_CSR_EN
    end else if (hit_msec) begin
      old_val = {29'b0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
    end else if (sel_pmr) begin
      old_val = pmr_off_q[idx];
    end else begin
      dec_err = 1'b1;
    end
`else
    end else if (hit_msec) begin
      old_val = {29'b0, mseccfg_q.rlb, mseccfg_q.mmwp, mseccfg_q.mml};
    end else begin
      dec_err = 1'b1;
    end
`endif

    unique case (req_op_q)
      CSR_WRITE: new_val = req_wdata_q;
      CSR_SET:   new_val = old_val | req_wdata_q;
      CSR_CLEAR: new_val = old_val & ~req_wdata_q;
      default:   new_val = old_val;
    endcase

    do_wr = !dec_err && ((req_op_q == CSR_WRITE) ||
                         ((req_op_q == CSR_SET || req_op_q == CSR_CLEAR) && req_wdata_q != 32'h0));

    // An address entry is frozen by its own L, or by the next entry's L when that entry is TOR
    addr_lock = (pmp_cfg_q[idx].lock ||
                 (idx != 4'hF && pmp_cfg_q[idx_nxt].lock && pmp_cfg_q[idx_nxt].mode == PMP_TOR)) &&
                !mseccfg_q.rlb;

    any_lock = 1'b0;
    for (int i = 0; i < 16; i++) begin
      any_lock = any_lock | pmp_cfg_q[i].lock;
    end

    for (int b = 0; b < 4; b++) begin
      cfg_we[b] = do_wr && hit_cfg &&
                  (int'({req_addr_q[1:0], 2'(b)}) < PMP_NUM_REGIONS) &&
                  !(pmp_cfg_q[{req_addr_q[1:0], 2'(b)}].lock && !mseccfg_q.rlb) &&
                  !(new_val[8*b +: 2] == 2'b10 && !mseccfg_q.mml) &&
                  !(new_val[8*b+3 +: 2] == PMP_NA4 && PMP_GRANULARITY >= 1);
    end

    addr_we = do_wr && hit_addr && (int'(idx) < PMP_NUM_REGIONS) && !addr_lock;
    msec_we = do_wr && hit_msec;
    rlb_we  = mseccfg_q.rlb || !any_lock;
`ifdef XPMP_PMR_CSR_EN
    pmr_we  = do_wr && sel_pmr && (int'(idx) < PMP_NUM_REGIONS) && !addr_lock;
`else
    pmr_we  = 1'b0;
`endif
  end

  // CHECK stage results, held for COMMIT and RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q   <= '0;
      err_q     <= 1'b0;
      new_q     <= '0;
      cfg_we_q  <= '0;
      addr_we_q <= 1'b0;
      msec_we_q <= 1'b0;
      rlb_we_q  <= 1'b0;
      pmr_we_q  <= 1'b0;
    end else if (state_q == S_CHECK) begin
      rdata_q   <= old_val;
      err_q     <= dec_err;
      new_q     <= new_val;
      cfg_we_q  <= cfg_we;
      addr_we_q <= addr_we;
      msec_we_q <= msec_we;
      rlb_we_q  <= rlb_we;
      pmr_we_q  <= pmr_we;
    end
  end

  // COMMIT: apply the pre-checked updates; nothing changes in any other state
  always_comb begin
    pmp_cfg_d  = pmp_cfg_q;
    pmp_addr_d = pmp_addr_q;
    mseccfg_d  = mseccfg_q;
`ifdef XPMP_PMR_CSR_EN
    pmr_off_d  = pmr_off_q;
`endif
    if (state_q == S_COMMIT) begin
      for (int b = 0; b < 4; b++) begin
        if (cfg_we_q[b]) begin
          pmp_cfg_d[{req_addr_q[1:0], 2'(b)}] = pmp_cfg_t'({new_q[8*b+7], 2'b00, new_q[8*b +: 5]});
        end
      end
      if (addr_we_q) pmp_addr_d[idx] = {new_q, 2'b00};
      if (msec_we_q) begin
        mseccfg_d.mml  = mseccfg_q.mml  | new_q[0];
        mseccfg_d.mmwp = mseccfg_q.mmwp | new_q[1];
        if (rlb_we_q) mseccfg_d.rlb = new_q[2];
      end
`ifdef XPMP_PMR_CSR_EN
      if (pmr_we_q) pmr_off_d[idx] = new_q;
`endif
    end
  end

  // Protection state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmp_cfg_q  <= '0;
      pmp_addr_q <= '0;
      mseccfg_q  <= '0;
`ifdef XPMP_PMR_CSR_EN
      pmr_off_q  <= '0;
`endif
    end else begin
      pmp_cfg_q  <= pmp_cfg_d;
      pmp_addr_q <= pmp_addr_d;
      mseccfg_q  <= mseccfg_d;
`ifdef XPMP_PMR_CSR_EN
      pmr_off_q  <= pmr_off_d;
`endif
    end
  end

  // Outputs
  always_comb begin
    csr_bus.req_ready    = (state_q == S_IDLE);
    csr_bus.resp_valid   = (state_q == S_RESP);
    csr_bus.resp_rdata   = rdata_q;
    csr_bus.resp_err     = err_q;
    csr_pmp_o.cfg        = pmp_cfg_q;
    csr_pmp_o.addr       = pmp_addr_q;
    csr_pmp_o.mseccfg    = mseccfg_q;
`ifdef XPMP_PMR_CSR_EN
    csr_pmp_o.pmraddroff = pmr_off_q;
`else
    csr_pmp_o.pmraddroff = '0;
`endif
  end

endmodule

// File: tb/tb_cv32e41s_pmp_csr_regs.sv
// tb/tb_cv32e41s_pmp_csr_regs.sv - scoreboard bench for cv32e41s_pmp_csr_regs
module tb_cv32e41s_pmp_csr_regs;
  import cv32e41s_pmp_csr_pkg::*;

  logic     clk;
  logic     rst_n;
  pmp_csr_t csr_pmp;
  int       cyc;
  int       n_chk;
  int       n_pass;

  cv32e41s_pmp_csr_regs_if bus ();

  cv32e41s_pmp_csr_regs #(
    .PMP_GRANULARITY (0),
    .PMP_NUM_REGIONS (4),
    .PMR_OFF_BASE    (12'hBD0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .csr_bus   (bus),
    .csr_pmp_o (csr_pmp)
  );

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
    int          hs;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Response monitor: pops the oldest expectation on every accepted response
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_rdata"}, 64'(bus.resp_rdata), 64'(e.rdata));
        chk({e.name, "_err"}, 64'(bus.resp_err), 64'(e.err));
        chk({e.name, "_latency"}, 64'(cyc - e.hs), 64'(e.lat));
      end
    end
  end

  task automatic do_req(input string nm, input logic [11:0] a, input logic [1:0] op,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int stall);
    int   n;
    exp_t e;
    @(negedge clk);
    if (stall > 0) bus.resp_ready = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n >= 16) fail_now({nm, "_ready_wait"});
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_op    = op;
    bus.req_wdata = wd;
    e.name  = nm;
    e.rdata = er;
    e.err   = ee;
    e.hs    = cyc;
    e.lat   = 3 + stall;
    exp_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({nm, "_ready_low"}, 64'(bus.req_ready), 64'(0));
    end
    if (stall > 0) begin
      repeat (stall - 1) begin
        @(negedge clk);
        chk({nm, "_valid_held"}, 64'(bus.resp_valid), 64'(1));
      end
      @(posedge clk);
      #1 bus.resp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    chk({nm, "_ready_after"}, 64'(bus.req_ready), 64'(1));
    n = 0;
    while (exp_q.size() != 0 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      fail_now({nm, "_response_wait"});
      exp_q.delete();
    end
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_op     = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_ready", 64'(bus.req_ready), 64'(1));
    chk("reset_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("reset_rdata", 64'(bus.resp_rdata), 64'(0));
    chk("reset_err", 64'(bus.resp_err), 64'(0));
    chk("reset_csr_pmp", 64'(|csr_pmp), 64'(0));

    do_req("rd_cfg0_reset", 12'h3A0, 2'b00, 32'h0, 32'h0, 1'b0, 0);
    do_req("wr_addr0", 12'h3B0, 2'b01, 32'h0000_1000, 32'h0, 1'b0, 0);
    chk("addr0_value", 64'(csr_pmp.addr[0]), 64'h4000);
    do_req("wr_cfg0_tor", 12'h3A0, 2'b01, 32'h0000_0F0F, 32'h0, 1'b0, 0);
    chk("cfg0_mode_tor", 64'(csr_pmp.cfg[0].mode), 64'(PMP_TOR));
    chk("cfg1_byte", 64'(csr_pmp.cfg[1]), 64'h0F);

`ifdef XPMP_PMR_CSR_EN
    do_req("wr_pmr0", 12'hBD0, 2'b01, 32'h8000_0100, 32'h0, 1'b0, 0);
    chk("pmr0_value", 64'(csr_pmp.pmraddroff[0]), 64'h8000_0100);
`else
    do_req("wr_pmr0", 12'hBD0, 2'b01, 32'h8000_0100, 32'h0, 1'b1, 0);
    chk("pmr0_tied_zero", 64'(csr_pmp.pmraddroff[0]), 64'h0);
`endif

    do_req("set_cfg1_lock", 12'h3A0, 2'b10, 32'h0000_8000, 32'h0000_0F0F, 1'b0, 0);
    chk("cfg1_locked", 64'(csr_pmp.cfg[1]), 64'h8F);
    do_req("wr_addr0_torlock", 12'h3B0, 2'b01, 32'h0000_2000, 32'h0000_1000, 1'b0, 0);
    do_req("rd_addr0_kept", 12'h3B0, 2'b00, 32'h0, 32'h0000_1000, 1'b0, 0);
    chk("addr0_kept", 64'(csr_pmp.addr[0]), 64'h4000);
    do_req("wr_rlb_locked", 12'h747, 2'b01, 32'h4, 32'h0, 1'b0, 0);
    do_req("rd_msec_zero", 12'h747, 2'b00, 32'h0, 32'h0, 1'b0, 2);
    do_req("wr_unmapped", 12'h123, 2'b01, 32'hFFFF, 32'h0, 1'b1, 0);
    do_req("wr_addr5_unimpl", 12'h3B5, 2'b01, 32'hABC, 32'h0, 1'b0, 0);
    do_req("rd_addr5_unimpl", 12'h3B5, 2'b00, 32'h0, 32'h0, 1'b0, 0);
    do_req("wr_cfg1_unimpl", 12'h3A1, 2'b01, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    do_req("rd_cfg1_unimpl", 12'h3A1, 2'b00, 32'h0, 32'h0, 1'b0, 0);
    do_req("set_zero_noop", 12'h3A0, 2'b10, 32'h0, 32'h0000_8F0F, 1'b0, 0);
    do_req("rd_cfg0_after_noop", 12'h3A0, 2'b00, 32'h0, 32'h0000_8F0F, 1'b0, 0);

    // Reset during COMMIT of a pmpaddr write: nothing commits, no response
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_addr  = 12'h3B2;
    bus.req_op    = 2'b01;
    bus.req_wdata = 32'h0000_1234;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midreset_addr2", 64'(csr_pmp.addr[2]), 64'h0);
    chk("midreset_state_clear", 64'(|csr_pmp), 64'(0));
    chk("midreset_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("midreset_ready", 64'(bus.req_ready), 64'(1));

    do_req("wr_rlb", 12'h747, 2'b01, 32'h4, 32'h0, 1'b0, 0);
    do_req("wr_addr0_b", 12'h3B0, 2'b01, 32'h0000_1000, 32'h0, 1'b0, 0);
    do_req("wr_cfg0_lock", 12'h3A0, 2'b01, 32'h0000_8F0F, 32'h0, 1'b0, 0);
    do_req("wr_addr0_rlb", 12'h3B0, 2'b01, 32'h0000_2000, 32'h0000_1000, 1'b0, 0);
    do_req("rd_addr0_rlb", 12'h3B0, 2'b00, 32'h0, 32'h0000_2000, 1'b0, 0);
    chk("addr0_rlb_value", 64'(csr_pmp.addr[0]), 64'h8000);
    do_req("wr_cfg_rw01", 12'h3A0, 2'b01, 32'h0000_0902, 32'h0000_8F0F, 1'b0, 0);
    do_req("rd_cfg_rw01", 12'h3A0, 2'b00, 32'h0, 32'h0000_090F, 1'b0, 0);
    do_req("wr_mml", 12'h747, 2'b01, 32'h1, 32'h4, 1'b0, 0);
    do_req("clr_mml", 12'h747, 2'b11, 32'h1, 32'h1, 1'b0, 0);
    do_req("rd_mml_sticky", 12'h747, 2'b00, 32'h0, 32'h1, 1'b0, 0);
    do_req("wr_mmwp", 12'h747, 2'b01, 32'h2, 32'h1, 1'b0, 0);
    do_req("rd_mmwp", 12'h747, 2'b00, 32'h0, 32'h3, 1'b0, 0);
    do_req("wr_cfg_rw01_mml", 12'h3A0, 2'b01, 32'h0000_0902, 32'h0000_090F, 1'b0, 0);
    do_req("rd_cfg_rw01_mml", 12'h3A0, 2'b00, 32'h0, 32'h0000_0902, 1'b0, 0);
    chk("cfg0_rw01_mml", 64'(csr_pmp.cfg[0]), 64'h02);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
